// File: rtl/spline_trajectory_streamer.sv
// Captures the spline approximation vector on start and replays it one sample at a time,
// paced by a step divider, with index and signed first difference on a valid/ready port.
module spline_trajectory_streamer #(
    parameter int N     = 6,
    parameter int IDX_W = 6,
    parameter int DIV_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [10*(N-1)*8-1:0]   approximation,
    input  logic [DIV_W-1:0]        step_div,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [7:0]              out_sample,
    output logic [IDX_W-1:0]        out_index,
    output logic signed [8:0]       out_delta,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned TOTAL = 10 * (N - 1);
    localparam int unsigned VW    = TOTAL * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PACE = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [VW-1:0]     shadow_q, shadow_d;
    logic [DIV_W-1:0]  div_q,    div_d;
    logic [DIV_W-1:0]  pace_q,   pace_d;
    logic [IDX_W-1:0]  index_q,  index_d;
    logic [7:0]        prev_q,   prev_d;
    logic [7:0]        sample_q, sample_d;
    logic signed [8:0] delta_q,  delta_d;
    logic [7:0]        cur_sample;

    always_comb begin
        cur_sample = '0;
        for (int unsigned k = 0; k < TOTAL; k++) begin
            if (index_q == IDX_W'(k)) begin
                cur_sample = shadow_q[k*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        div_d    = div_q;
        pace_d   = pace_q;
        index_d  = index_q;
        prev_d   = prev_q;
        sample_d = sample_q;
        delta_d  = delta_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d = approximation;
                    div_d    = step_div;
                    pace_d   = step_div;
                    index_d  = '0;
                    prev_d   = '0;
                    state_d  = S_PACE;
                end
            end
            S_PACE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pace_q == '0) begin
                    // Output registers load on entry to SEND so they hold through any stall.
                    state_d  = S_SEND;
                    sample_d = cur_sample;
                    if (index_q == '0) begin
                        delta_d = '0;
                    end else begin
                        delta_d = {1'b0, cur_sample} - {1'b0, prev_q};
                    end
                end else begin
                    pace_d = pace_q - 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    prev_d = cur_sample;
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        pace_d  = div_q;
                        state_d = S_PACE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            div_q    <= '0;
            pace_q   <= '0;
            index_q  <= '0;
            prev_q   <= '0;
            sample_q <= '0;
            delta_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            div_q    <= div_d;
            pace_q   <= pace_d;
            index_q  <= index_d;
            prev_q   <= prev_d;
            sample_q <= sample_d;
            delta_q  <= delta_d;
        end
    end

    assign out_valid  = (state_q == S_SEND);
    assign out_sample = sample_q;
    assign out_index  = index_q;
    assign out_delta  = delta_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_spline_trajectory_streamer.sv
// Bench for spline_trajectory_streamer: table-driven stream scenarios plus abort and reset
// sequences; every accepted sample is checked against a scoreboard queue.
module tb_spline_trajectory_streamer;

    localparam int N     = 6;
    localparam int IDX_W = 6;
    localparam int DIV_W = 8;
    localparam int TOTAL = 10 * (N - 1);
    localparam int VW    = TOTAL * 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [VW-1:0]     approximation;
    logic [DIV_W-1:0]  step_div;
    logic              out_ready;
    logic              out_valid;
    logic [7:0]        out_sample;
    logic [IDX_W-1:0]  out_index;
    logic signed [8:0] out_delta;
    logic              busy;
    logic              done;

    spline_trajectory_streamer #(.N(N), .IDX_W(IDX_W), .DIV_W(DIV_W)) dut (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .approximation(approximation),
        .step_div     (step_div),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_sample   (out_sample),
        .out_index    (out_index),
        .out_delta    (out_delta),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int idx;
        int smp;
        int dlt;
    } exp_t;

    typedef struct {
        int pat;
        int div;
        int mode;
        bit abort_at_start;
        int exp_lat;
        int exp_total;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[4];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [VW-1:0] make_vec(input int pat);
        logic [VW-1:0] v;
        int s;
        v = '0;
        for (int k = 0; k < TOTAL; k++) begin
            case (pat)
                0: s = 2 * k;
                1: s = (k == 0) ? 255 : (k == 1) ? 0 : (k == 2) ? 200 : ((k * 37) % 256);
                default: s = int'($urandom_range(0, 255));
            endcase
            v[k*8 +: 8] = 8'(s);
        end
        return v;
    endfunction

    task automatic push_expected(input logic [VW-1:0] v);
        exp_t e;
        int prev;
        prev = 0;
        for (int k = 0; k < TOTAL; k++) begin
            e.idx = k;
            e.smp = int'(v[k*8 +: 8]);
            e.dlt = (k == 0) ? 0 : e.smp - prev;
            prev  = e.smp;
            sb_q.push_back(e);
        end
    endtask

    // Drives one start pulse (optionally with abort) and scrambles the upstream inputs afterward.
    task automatic begin_stream(input logic [VW-1:0] v, input int d, input bit with_abort);
        push_expected(v);
        approximation = v;
        step_div      = DIV_W'(d);
        start         = 1'b1;
        abort         = with_abort;
        @(posedge clk); #1;
        start         = 1'b0;
        abort         = 1'b0;
        approximation = make_vec(2);
        step_div      = DIV_W'($urandom_range(0, 255));
    endtask

    task automatic run_stream(input logic [VW-1:0] v, input int d, input int mode,
                              input bit with_abort, output int lat, output int total,
                              output int dones, output int busy_lo);
        int stall;
        lat = -1; total = -1; dones = 0; busy_lo = 0; stall = 0;
        out_ready = 1'b1;
        begin_stream(v, d, with_abort);
        for (int c = 0; c < 4000; c++) begin
            if (out_valid && lat < 0) lat = c + 1;
            if (done) begin
                dones++;
                if (total < 0) total = c;
            end else if (total < 0 && !busy) begin
                busy_lo++;
            end
            if (total >= 0 && c >= total + 3) break;
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (out_valid && out_index == 6'd10 && stall < 7) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = (c % 2 == 1);
            end
            start = (c == 7);
            if (c == 7) approximation = make_vec(2);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    bit   stall_pend = 1'b0;
    int   st_smp, st_idx, st_dlt;

    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid) begin
            if (stall_pend) begin
                check("stall_hold_sample", int'(out_sample), st_smp);
                check("stall_hold_index", int'(out_index), st_idx);
                check("stall_hold_delta", int'(out_delta), st_dlt);
            end
            if (out_ready && !abort) begin
                stall_pend = 1'b0;
                if (sb_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL sb_underflow: got index %0d, expected no output", out_index);
                end else begin
                    e = sb_q.pop_front();
                    check("out_index", int'(out_index), e.idx);
                    check("out_sample", int'(out_sample), e.smp);
                    check("out_delta", int'(out_delta), e.dlt);
                end
            end else if (!out_ready && !abort) begin
                stall_pend = 1'b1;
                st_smp = int'(out_sample);
                st_idx = int'(out_index);
                st_dlt = int'(out_delta);
            end else begin
                stall_pend = 1'b0;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    int lat, total, dones, busy_lo, found, done_seen;

    initial begin
        tbl[0] = '{pat: 0, div: 0, mode: 0, abort_at_start: 1'b0, exp_lat: 2, exp_total: 100};
        tbl[1] = '{pat: 0, div: 3, mode: 0, abort_at_start: 1'b0, exp_lat: 5, exp_total: 250};
        tbl[2] = '{pat: 0, div: 0, mode: 1, abort_at_start: 1'b0, exp_lat: 2, exp_total: 0};
        tbl[3] = '{pat: 1, div: 1, mode: 0, abort_at_start: 1'b1, exp_lat: 3, exp_total: 150};

        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        approximation = make_vec(2); step_div = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_delta", int'(out_delta), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1;

        // abort alone in IDLE must not start anything
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);

        for (int unsigned i = 0; i < 4; i++) begin
            run_stream(make_vec(tbl[i].pat), tbl[i].div, tbl[i].mode, tbl[i].abort_at_start,
                       lat, total, dones, busy_lo);
            check($sformatf("t%0d_first_valid_edges", i), lat, tbl[i].exp_lat);
            if (tbl[i].exp_total > 0) check($sformatf("t%0d_stream_cycles", i), total, tbl[i].exp_total);
            check($sformatf("t%0d_done_pulses", i), dones, 1);
            check($sformatf("t%0d_busy_dropouts", i), busy_lo, 0);
            check($sformatf("t%0d_samples_left", i), sb_q.size(), 0);
            sb_q.delete();
        end

        // Abort at index 20 with out_ready high
        out_ready = 1'b1;
        begin_stream(make_vec(2), 0, 1'b0);
        found = 0;
        for (int c = 0; c < 500; c++) begin
            if (out_valid && out_index == 6'd20) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort_reached_idx20", found, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_samples_left", sb_q.size(), TOTAL - 20);
        sb_q.delete();
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        check("abort_no_done", done_seen, 0);

        run_stream(make_vec(2), 2, 0, 1'b0, lat, total, dones, busy_lo);
        check("restart_first_valid_edges", lat, 4);
        check("restart_stream_cycles", total, 200);
        check("restart_done_pulses", dones, 1);
        check("restart_samples_left", sb_q.size(), 0);
        sb_q.delete();

        // Reset for one edge at index 30
        begin_stream(make_vec(0), 1, 1'b0);
        found = 0;
        for (int c = 0; c < 500; c++) begin
            if (out_valid && out_index == 6'd30) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reset_reached_idx30", found, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_sample", int'(out_sample), 0);
        check("mid_rst_out_index", int'(out_index), 0);
        check("mid_rst_out_delta", int'(out_delta), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        reset = 1'b1;
        sb_q.delete();

        run_stream(make_vec(1), 0, 0, 1'b0, lat, total, dones, busy_lo);
        check("post_rst_first_valid_edges", lat, 2);
        check("post_rst_stream_cycles", total, 100);
        check("post_rst_done_pulses", dones, 1);
        check("post_rst_samples_left", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
